// File: rtl/image_filter_arbiter.sv
// rtl/image_filter_arbiter.sv - round-robin arbiter sharing one window filter among several requesters
//
// Purpose: grants one requester window beat per cycle to a single filter, reloading the
// filter config (after draining in-flight beats) when the winner needs a different config,
// and routes filter results back to the issuing requester in issue order.
//
// Ports:
//   i_clk, i_rst                     rising-edge clock, asynchronous active-high reset
//   i_req_valid / o_req_ready        per-requester beat handshake
//   i_req_data, i_req_config         per-requester window beat and required filter config
//   o_rsp_valid / i_rsp_ready        per-requester response handshake
//   o_rsp_data                       shared response bus, qualified by o_rsp_valid
//   o_flt_config                     config currently loaded into the filter
//   o_flt_in_valid / i_flt_in_ready  filter input handshake, o_flt_in_data window beat
//   i_flt_out_valid / o_flt_out_ready filter output handshake, i_flt_out_data result
//   o_outstanding                    beats issued to the filter and not yet returned
//   o_busy                           not idle in arbitration or beats still in flight
//   o_err_orphan                     sticky: filter produced a result with nothing in flight

module image_filter_arbiter_tag_fifo #(
  parameter int p_width = 2,
  parameter int p_depth = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [p_width-1:0]        i_push_data,
  input  logic                      i_pop,
  output logic [p_width-1:0]        o_head,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [$clog2(p_depth):0]  o_count
);
  localparam int lp_ptr_w = $clog2(p_depth);
  localparam int lp_cnt_w = lp_ptr_w + 1;
  localparam logic [lp_cnt_w-1:0] lp_full_cnt = lp_cnt_w'(p_depth);

  logic [p_width-1:0]  mem [p_depth];
  logic [lp_ptr_w-1:0] wr_ptr;
  logic [lp_ptr_w-1:0] rd_ptr;
  logic [lp_cnt_w-1:0] count;
  logic                do_push;
  logic                do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == lp_full_cnt);
  assign o_count = count;
  assign o_head  = mem[rd_ptr];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_push_data;
  end
endmodule

module image_filter_arbiter #(
  parameter int p_data_bw   = 10,
  parameter int p_win_size  = 9,
  parameter int p_num_req   = 4,
  parameter int p_tag_depth = 8
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst,
  input  logic [p_num_req-1:0]                                i_req_valid,
  output logic [p_num_req-1:0]                                o_req_ready,
  input  logic [p_num_req-1:0][p_win_size-1:0][p_data_bw-1:0] i_req_data,
  input  logic [p_num_req-1:0][p_data_bw-1:0]                 i_req_config,
  output logic [p_num_req-1:0]                                o_rsp_valid,
  input  logic [p_num_req-1:0]                                i_rsp_ready,
  output logic [p_data_bw-1:0]                                o_rsp_data,
  output logic [p_data_bw-1:0]                                o_flt_config,
  output logic                                                o_flt_in_valid,
  input  logic                                                i_flt_in_ready,
  output logic [p_win_size-1:0][p_data_bw-1:0]                o_flt_in_data,
  input  logic                                                i_flt_out_valid,
  output logic                                                o_flt_out_ready,
  input  logic [p_data_bw-1:0]                                i_flt_out_data,
  output logic [$clog2(p_tag_depth):0]                        o_outstanding,
  output logic                                                o_busy,
  output logic                                                o_err_orphan
);
  localparam int lp_idx_w = $clog2(p_num_req);
  localparam logic [lp_idx_w-1:0] lp_last_idx = lp_idx_w'(p_num_req - 1);

  typedef enum logic [1:0] {
    ST_ARB,
    ST_DRAIN,
    ST_LOAD
  } state_t;

  state_t                         state;
  logic [lp_idx_w-1:0]            rr_ptr;
  logic [lp_idx_w-1:0]            pend;
  logic [p_data_bw-1:0]           cfg_reg;
  logic [lp_idx_w-1:0]            win;
  logic [lp_idx_w-1:0]            win_next;
  logic [lp_idx_w-1:0]            head;
  logic                           any_valid;
  logic                           cfg_match;
  logic                           in_hs;
  logic                           rsp_hs;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic [$clog2(p_tag_depth):0]   fifo_count;

  // Winner: first valid requester at or after rr_ptr, wrapping modulo p_num_req.
  always_comb begin : winner_search
    int                  idx;
    logic [lp_idx_w-1:0] cand;
    any_valid = 1'b0;
    win       = rr_ptr;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < p_num_req; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= p_num_req) idx = idx - p_num_req;
      cand = idx[lp_idx_w-1:0];
      if (!any_valid && i_req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  assign cfg_match = (i_req_config[win] == cfg_reg);
  assign win_next  = (win == lp_last_idx) ? '0 : win + 1'b1;

  // Request path is purely combinational; a config mismatch issues nothing and
  // lets the FSM start draining on the clock edge.
  always_comb begin
    o_req_ready    = '0;
    o_flt_in_valid = 1'b0;
    o_flt_in_data  = i_req_data[win];
    if (!i_rst && (state == ST_ARB) && any_valid && cfg_match && !fifo_full) begin
      o_flt_in_valid   = 1'b1;
      o_req_ready[win] = i_flt_in_ready;
    end
  end

  assign in_hs = o_flt_in_valid && i_flt_in_ready;

  // Response path: only the oldest in-flight tag may see the filter result.
  always_comb begin
    o_rsp_valid     = '0;
    o_flt_out_ready = 1'b0;
    if (!i_rst && !fifo_empty) begin
      o_rsp_valid[head] = i_flt_out_valid;
      o_flt_out_ready   = i_rsp_ready[head];
    end
  end

  assign o_rsp_data = i_flt_out_data;
  assign rsp_hs     = o_flt_out_ready && i_flt_out_valid;

  image_filter_arbiter_tag_fifo #(
    .p_width (lp_idx_w),
    .p_depth (p_tag_depth)
  ) u_tag_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (in_hs),
    .i_push_data (win),
    .i_pop       (rsp_hs),
    .o_head      (head),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full),
    .o_count     (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_ARB;
      rr_ptr       <= '0;
      pend         <= '0;
      cfg_reg      <= '0;
      o_err_orphan <= 1'b0;
    end else begin
      if (fifo_empty && i_flt_out_valid) o_err_orphan <= 1'b1;
      case (state)
        ST_ARB: begin
          if (any_valid) begin
            if (!cfg_match) begin
              pend  <= win;
              state <= ST_DRAIN;
            end else if (in_hs) begin
              rr_ptr <= win_next;
            end
          end
        end
        // The config may only change once every issued beat has come back.
        ST_DRAIN: begin
          if (fifo_count == '0) state <= ST_LOAD;
        end
        // Pointing rr_ptr at pend guarantees the requester that caused the
        // reload wins the very next arbitration.
        ST_LOAD: begin
          cfg_reg <= i_req_config[pend];
          rr_ptr  <= pend;
          state   <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign o_flt_config  = cfg_reg;
  assign o_outstanding = fifo_count;
  assign o_busy        = !i_rst && ((state != ST_ARB) || (fifo_count != '0));
endmodule

// File: doc/image_filter_arbiter.md
IMAGE_FILTER_ARBITER -- requirements
Module: image_filter_arbiter

Interface
REQ-001 The block SHALL have parameter p_data_bw, default 10, giving pixel and config width.
REQ-002 The block SHALL have parameter p_win_size, default 9, giving the number of pixels per window beat.
REQ-003 The block SHALL have parameter p_num_req, default 4, giving the number of requesters (2..8).
REQ-004 The block SHALL have parameter p_tag_depth, default 8, giving the outstanding-beat FIFO depth (power of 2, >=2).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: i_clk in 1 (rising-edge clock) and i_rst in 1 (async active-high reset).
REQ-006 The block SHALL have the requester-side ports i_req_valid in [p_num_req], o_req_ready out [p_num_req], i_req_data in [p_num_req][p_win_size] x p_data_bw, and i_req_config in [p_num_req] x p_data_bw.
REQ-007 The block SHALL have the response ports o_rsp_valid out [p_num_req], i_rsp_ready in [p_num_req], and o_rsp_data out p_data_bw (shared bus, qualified by o_rsp_valid).
REQ-008 The block SHALL have the filter-side ports o_flt_config out p_data_bw, o_flt_in_valid out 1, i_flt_in_ready in 1, o_flt_in_data out [p_win_size] x p_data_bw, i_flt_out_valid in 1, o_flt_out_ready out 1, and i_flt_out_data in p_data_bw.
REQ-009 The block SHALL have the status ports o_outstanding out clog2(p_tag_depth)+1 (beats in flight), o_busy out 1 (state != ARB or o_outstanding != 0), and o_err_orphan out 1 (sticky flag).

Function
REQ-010 The FSM SHALL have states ARB, DRAIN and LOAD, plus a registered config cfg_reg driving o_flt_config, a round-robin pointer rr_ptr, and a tag FIFO of requester indices.
REQ-011 In ARB, the winner w SHALL be the first index with i_req_valid set, searching from rr_ptr upward modulo p_num_req.
REQ-012 In ARB, if i_req_config[w]==cfg_reg, the block SHALL drive o_flt_in_valid=1 and o_flt_in_data=i_req_data[w], and set o_req_ready[w]=i_flt_in_ready & !fifo_full, with all other o_req_ready at 0.
REQ-013 The request path SHALL be combinational (zero added latency), and o_flt_in_valid SHALL be 0 when fifo_full.
REQ-014 On a filter input handshake, the block SHALL push w into the tag FIFO and set rr_ptr to (w+1) mod p_num_req.
REQ-015 In ARB, if i_req_config[w]!=cfg_reg, the block SHALL latch w into pend, accept no beat that cycle, and go to DRAIN.
REQ-016 In DRAIN, the block SHALL hold o_flt_in_valid=0 and all o_req_ready=0, and go to LOAD in the cycle after o_outstanding reaches 0 (immediately next cycle if already 0).
REQ-017 LOAD SHALL last exactly 1 cycle, setting cfg_reg<=i_req_config[pend] and rr_ptr<=pend, then going to ARB, so pend wins the next arbitration.
REQ-018 Requesters SHALL hold valid, data and config stable until accepted, and the block SHALL NOT check this.
REQ-019 With no i_req_valid set in ARB, the block SHALL stay in ARB and leave rr_ptr unchanged.
REQ-020 For responses, with head=tag FIFO head and the FIFO non-empty, the block SHALL drive o_rsp_valid[head]=i_flt_out_valid, o_rsp_data=i_flt_out_data and o_flt_out_ready=i_rsp_ready[head], and pop on handshake; the response path SHALL be combinational.
REQ-021 Responses SHALL be returned in issue order, and no requester other than head SHALL see o_rsp_valid.
REQ-022 When the FIFO is empty, the block SHALL drive o_flt_out_ready=0 and all o_rsp_valid=0, and i_flt_out_valid=1 SHALL set o_err_orphan, which stays set until reset.
REQ-023 When the FIFO is full, push SHALL be blocked even if a pop occurs the same cycle, and a simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-024 o_outstanding SHALL equal the FIFO occupancy, 0..p_tag_depth.

Reset
REQ-025 On i_rst=1, asynchronously, the block SHALL set state=ARB, rr_ptr=0, cfg_reg=0, pend=0, FIFO empty, o_outstanding=0 and o_err_orphan=0.
REQ-026 During reset, the block SHALL drive o_req_ready, o_flt_in_valid, o_rsp_valid and o_flt_out_ready to 0, and o_busy to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight tags, and filter outputs that arrive after reset release SHALL set o_err_orphan.

Verification
REQ-028 Round-robin fairness: all 4 requesters continuously valid with config 0, filter always ready -> accepts ordered 0,1,2,3,0,... and responses routed to matching o_rsp_valid index.
REQ-029 Config switch: req0 cfg 0 with 3 beats in flight, req1 valid with cfg 2 -> DRAIN until o_outstanding=0, LOAD 1 cycle, o_flt_config=2, next accept is req1.
REQ-030 FIFO full: p_tag_depth=8, filter output ready held 0 -> exactly 8 accepts, o_outstanding=8, o_flt_in_valid=0 until the first pop.
REQ-031 Response backpressure: head requester i_rsp_ready=0 while another requester is ready -> o_flt_out_ready=0, no pop, order preserved.
REQ-032 Orphan: i_flt_out_valid=1 with the FIFO empty -> o_err_orphan=1, held until i_rst.
REQ-033 Async reset: assert i_rst mid-DRAIN, between clock edges -> outputs return to reset values immediately, state ARB, o_outstanding=0.
